// File: rtl/sw_input_sequencer_if.sv
// CPU-facing operand bus of sw_input_sequencer: master drives the operand, slave (cpu) returns the ack.
// Handshake: in_valid rises together with a new inport word and holds until a clock edge samples
// cpu_ack=1; inport is stable while in_valid=1; cpu_ack sampled while in_valid=0 has no effect.
interface sw_input_sequencer_if #(
  parameter int DW      = 8,
  parameter int NUM_OPS = 2
);
  localparam int IW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  logic [DW-1:0] inport;
  logic          in_valid;
  logic [IW-1:0] op_idx;
  logic          txn_done;
  logic          err;
  logic          cpu_ack;

  modport master (output inport, in_valid, op_idx, txn_done, err, input cpu_ack);
  modport slave  (input inport, in_valid, op_idx, txn_done, err, output cpu_ack);
endinterface

// File: rtl/sw_input_sequencer.sv
// Synchronises and debounces the SW8 go switch, latches SW[DW-1:0] once per go press and offers it to the cpu.
// Optional feature macro SW_SEQ_TIMEOUT_EN: abandon an unacked operand after TIMEOUT cycles and set sticky err.
module sw_input_sequencer #(
  parameter int DW         = 8,
  parameter int DEB_CYCLES = 4,
  parameter int NUM_OPS    = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sw_go,
  input  logic [DW-1:0]          sw_data,
  sw_input_sequencer_if.master   bus,
  output logic [1:0]             dbg_state
);
  localparam int IW  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int DCW = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_ACK, WAIT_REL} state_t;

  state_t         state;
  logic           go_m, go_s, go_db;
  logic [DCW-1:0] deb_cnt;
  logic [DW-1:0]  inport_q;
  logic           in_valid_q;
  logic [IW-1:0]  op_idx_q;
  logic           txn_done_q;
  logic           err_q;

  // go_db only follows go_s after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_m    <= 1'b0;
      go_s    <= 1'b0;
      go_db   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      go_m <= sw_go;
      go_s <= go_m;
      if (go_s == go_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DCW'(DEB_CYCLES - 1)) begin
        go_db   <= go_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DCW'(1);
      end
    end
  end

`ifdef SW_SEQ_TIMEOUT_EN
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TCW-1:0] tmo_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign err_q          = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      inport_q   <= '0;
      in_valid_q <= 1'b0;
      op_idx_q   <= '0;
      txn_done_q <= 1'b0;
`ifdef SW_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      txn_done_q <= 1'b0;
      case (state)
        IDLE: if (go_db) state <= CAPTURE;
        CAPTURE: begin
          inport_q   <= sw_data;
          in_valid_q <= 1'b1;
          state      <= WAIT_ACK;
`ifdef SW_SEQ_TIMEOUT_EN
          tmo_cnt    <= '0;
`endif
        end
        WAIT_ACK: begin
          // an ack arriving together with a go edge wins; WAIT_REL looks at go_db afterwards
          if (bus.cpu_ack) begin
            in_valid_q <= 1'b0;
            state      <= WAIT_REL;
            if (op_idx_q == IW'(NUM_OPS - 1)) begin
              op_idx_q   <= '0;
              txn_done_q <= 1'b1;
            end else begin
              op_idx_q <= op_idx_q + IW'(1);
            end
          end
`ifdef SW_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TCW'(TIMEOUT - 1)) begin
            in_valid_q <= 1'b0;
            err_q      <= 1'b1;
            op_idx_q   <= '0;
            state      <= WAIT_REL;
          end else begin
            tmo_cnt <= tmo_cnt + TCW'(1);
          end
`endif
        end
        WAIT_REL: if (!go_db) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign bus.inport   = inport_q;
  assign bus.in_valid = in_valid_q;
  assign bus.op_idx   = op_idx_q;
  assign bus.txn_done = txn_done_q;
  assign bus.err      = err_q;
  assign dbg_state    = state;
endmodule
